// File: rtl/fp_adder.sv
// rtl/fp_adder.sv - multi-cycle IEEE-754 binary floating-point adder
//
// Purpose: responder on the add_* start/ready handshake. Operands are captured
// on a qualified start strobe, then pass through unpack/align/add/normalize/
// round states. The rounded sum is published with a one-cycle ready pulse.
// Latency is fixed at 6 edges from the start edge.
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-high
//   enable     start qualifier
//   add_a      operand A, sampled with start
//   add_b      operand B, sampled with start
//   add_start  one-cycle request strobe
//   add_ready  one-cycle pulse, add_sum valid
//   add_sum    result, held until the next result
module fp_adder #(
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [EXP_LEN+MANTISSA_LEN:0]   add_a,
    input  logic [EXP_LEN+MANTISSA_LEN:0]   add_b,
    input  logic                            add_start,
    output logic                            add_ready,
    output logic [EXP_LEN+MANTISSA_LEN:0]   add_sum
);
    localparam int E   = EXP_LEN;
    localparam int M   = MANTISSA_LEN;
    localparam int W   = 1 + E + M;
    localparam int SW  = M + 4;              // hidden + frac + guard + round + sticky
    localparam int LZW = $clog2(SW + 1);
    localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t          r_state, w_next;
    logic [W-1:0]    r_a, r_b;
    logic            r_sign_l, r_sign_s;
    logic [E-1:0]    r_exp_l, r_exp_s;
    logic [M:0]      r_sig_l, r_sig_s;
    logic            r_special;
    logic [W-1:0]    r_special_val;
    logic [SW-1:0]   r_ext_l, r_ext_s;
    logic            r_eq_sign;
    logic [SW:0]     r_sum;
    logic [SW-1:0]   r_norm;
    logic [E:0]      r_nexp;
    logic            r_zero, r_zsign;
    logic [W-1:0]    r_result;
    logic            r_ready;
    logic [W-1:0]    r_sum_out;

    assign add_ready = r_ready;
    assign add_sum   = r_sum_out;

    function automatic logic [LZW-1:0] f_lzc(input logic [SW-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + LZW'(1);
            end
        end
        return n;
    endfunction

    // ---------------- unpack ----------------
    logic          w_sign_a, w_sign_b;
    logic [E-1:0]  w_exp_a, w_exp_b;
    logic [M-1:0]  w_frac_a, w_frac_b;
    logic          w_zexp_a, w_zexp_b, w_mexp_a, w_mexp_b;
    logic [M-1:0]  w_fracf_a, w_fracf_b;
    logic          w_nan_a, w_nan_b, w_inf_a, w_inf_b;
    logic          w_a_ge_b;
    logic          w_special;
    logic [W-1:0]  w_special_val;

    assign w_sign_a  = r_a[W-1];
    assign w_sign_b  = r_b[W-1];
    assign w_exp_a   = r_a[W-2:M];
    assign w_exp_b   = r_b[W-2:M];
    assign w_frac_a  = r_a[M-1:0];
    assign w_frac_b  = r_b[M-1:0];
    assign w_zexp_a  = (w_exp_a == '0);
    assign w_zexp_b  = (w_exp_b == '0);
    assign w_mexp_a  = &w_exp_a;
    assign w_mexp_b  = &w_exp_b;
    // Denormals flush to zero: drop their fraction entirely.
    assign w_fracf_a = w_zexp_a ? '0 : w_frac_a;
    assign w_fracf_b = w_zexp_b ? '0 : w_frac_b;
    assign w_nan_a   = w_mexp_a & (|w_frac_a);
    assign w_nan_b   = w_mexp_b & (|w_frac_b);
    assign w_inf_a   = w_mexp_a & ~(|w_frac_a);
    assign w_inf_b   = w_mexp_b & ~(|w_frac_b);
    assign w_a_ge_b  = {w_exp_a, w_fracf_a} >= {w_exp_b, w_fracf_b};

    always_comb begin
        w_special     = 1'b0;
        w_special_val = '0;
        if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sign_a != w_sign_b))) begin
            w_special     = 1'b1;
            w_special_val = QNAN;
        end else if (w_inf_a) begin
            w_special     = 1'b1;
            w_special_val = r_a;
        end else if (w_inf_b) begin
            w_special     = 1'b1;
            w_special_val = r_b;
        end
    end

    // ---------------- align ----------------
    logic [E-1:0]  w_diff;
    logic [SW-1:0] w_ext_s0, w_mask, w_aligned;
    logic          w_big;

    assign w_diff   = r_exp_l - r_exp_s;
    assign w_ext_s0 = {r_sig_s, 3'b000};
    assign w_mask   = ~({SW{1'b1}} << w_diff);
    assign w_big    = 32'(w_diff) >= 32'(SW);

    always_comb begin
        w_aligned = '0;
        if (w_big) begin
            w_aligned = {{(SW-1){1'b0}}, |r_sig_s};
        end else begin
            // Bits shifted past the sticky position are OR-ed back into it.
            w_aligned = (w_ext_s0 >> w_diff) | {{(SW-1){1'b0}}, |(w_ext_s0 & w_mask)};
        end
    end

    // ---------------- add ----------------
    logic [SW:0] w_sum;
    assign w_sum = r_eq_sign ? ({1'b0, r_ext_l} + {1'b0, r_ext_s})
                             : ({1'b0, r_ext_l} - {1'b0, r_ext_s});

    // ---------------- normalize ----------------
    logic [LZW-1:0] w_lzc;
    logic [SW-1:0]  w_norm;
    logic [E:0]     w_nexp;
    logic           w_zero, w_zsign;

    assign w_lzc = f_lzc(r_sum[SW-1:0]);

    always_comb begin
        w_norm  = '0;
        w_nexp  = '0;
        w_zero  = 1'b0;
        // Exact zero: same-sign zeros keep their sign, anything else is +0.
        w_zsign = r_eq_sign ? r_sign_l : 1'b0;
        if (r_sum == '0) begin
            w_zero = 1'b1;
        end else if (r_sum[SW]) begin
            w_norm = {r_sum[SW:2], r_sum[1] | r_sum[0]};
            w_nexp = {1'b0, r_exp_l} + (E+1)'(1);
        end else if (32'(r_exp_l) <= 32'(w_lzc)) begin
            w_zero  = 1'b1;
            w_zsign = r_sign_l;
        end else begin
            w_norm = r_sum[SW-1:0] << w_lzc;
            w_nexp = {1'b0, r_exp_l} - (E+1)'(w_lzc);
        end
    end

    // ---------------- round ----------------
    logic          w_rup;
    logic [M+1:0]  w_mant;
    logic [E:0]    w_fexp;
    logic [M-1:0]  w_frac;
    logic          w_ovf;
    logic [W-1:0]  w_result;

    assign w_rup  = r_norm[2] & (r_norm[1] | r_norm[0] | r_norm[3]);
    assign w_mant = {1'b0, r_norm[SW-1:3]} + {{(M+1){1'b0}}, w_rup};
    assign w_fexp = r_nexp + {{E{1'b0}}, w_mant[M+1]};
    assign w_frac = w_mant[M+1] ? w_mant[M:1] : w_mant[M-1:0];
    assign w_ovf  = w_fexp >= {1'b0, {E{1'b1}}};

    always_comb begin
        w_result = {r_sign_l, w_fexp[E-1:0], w_frac};
        if (r_zero)     w_result = {r_zsign, {(W-1){1'b0}}};
        else if (w_ovf) w_result = {r_sign_l, {E{1'b1}}, {M{1'b0}}};
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (add_start && enable) w_next = UNPACK;
            UNPACK:  w_next = ALIGN;
            ALIGN:   w_next = ADD;
            ADD:     w_next = NORM;
            NORM:    w_next = ROUND;
            ROUND:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a           <= '0;
            r_b           <= '0;
            r_sign_l      <= 1'b0;
            r_sign_s      <= 1'b0;
            r_exp_l       <= '0;
            r_exp_s       <= '0;
            r_sig_l       <= '0;
            r_sig_s       <= '0;
            r_special     <= 1'b0;
            r_special_val <= '0;
            r_ext_l       <= '0;
            r_ext_s       <= '0;
            r_eq_sign     <= 1'b0;
            r_sum         <= '0;
            r_norm        <= '0;
            r_nexp        <= '0;
            r_zero        <= 1'b0;
            r_zsign       <= 1'b0;
            r_result      <= '0;
            r_ready       <= 1'b0;
            r_sum_out     <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (add_start && enable) begin
                        r_a <= add_a;
                        r_b <= add_b;
                    end
                end
                UNPACK: begin
                    r_special     <= w_special;
                    r_special_val <= w_special_val;
                    if (w_a_ge_b) begin
                        r_sign_l <= w_sign_a;  r_exp_l <= w_exp_a;  r_sig_l <= {~w_zexp_a, w_fracf_a};
                        r_sign_s <= w_sign_b;  r_exp_s <= w_exp_b;  r_sig_s <= {~w_zexp_b, w_fracf_b};
                    end else begin
                        r_sign_l <= w_sign_b;  r_exp_l <= w_exp_b;  r_sig_l <= {~w_zexp_b, w_fracf_b};
                        r_sign_s <= w_sign_a;  r_exp_s <= w_exp_a;  r_sig_s <= {~w_zexp_a, w_fracf_a};
                    end
                end
                ALIGN: begin
                    r_ext_l   <= {r_sig_l, 3'b000};
                    r_ext_s   <= w_aligned;
                    r_eq_sign <= (r_sign_l == r_sign_s);
                end
                ADD: begin
                    r_sum <= w_sum;
                end
                NORM: begin
                    r_norm  <= w_norm;
                    r_nexp  <= w_nexp;
                    r_zero  <= w_zero;
                    r_zsign <= w_zsign;
                end
                ROUND: begin
                    r_result <= r_special ? r_special_val : w_result;
                end
                DONE: begin
                    r_sum_out <= r_result;
                    r_ready   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_adder.sv
// tb/tb_fp_adder.sv - self-checking bench for fp_adder
module tb_fp_adder;
    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_start;
    logic        add_ready;
    logic [31:0] add_sum;

    int n_pass  = 0;
    int n_total = 0;

    fp_adder #(.EXP_LEN(8), .MANTISSA_LEN(23)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_start (add_start),
        .add_ready (add_ready),
        .add_sum   (add_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_total++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, expv);
    endtask

    // Issues one start; returns at the negedge where add_ready is seen.
    // lat counts edges after the start edge (-1 on timeout).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] sum, output int lat);
        @(negedge clk);
        add_a = a; add_b = b; add_start = 1'b1; enable = 1'b1;
        @(negedge clk);
        add_start = 1'b0;
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            if (add_ready) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        sum = add_sum;
    endtask

    // Counts ready pulses over a window of cycles.
    task automatic count_ready(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (add_ready) pulses++;
        end
    endtask

    initial begin
        logic [31:0] sum;
        int          lat;
        int          pulses;
        int          unstable;
        int          n;

        vecs[0]  = '{32'h3F800000, 32'h40000000, 32'h40400000};
        vecs[1]  = '{32'h40A00000, 32'hBFC00000, 32'h40600000};
        vecs[2]  = '{32'h40490FDB, 32'hC0490FDB, 32'h00000000};
        vecs[3]  = '{32'h3F800000, 32'h33800000, 32'h3F800000};
        vecs[4]  = '{32'h3F800001, 32'h33800000, 32'h3F800002};
        vecs[5]  = '{32'h3F800000, 32'h33000000, 32'h3F800000};
        vecs[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
        vecs[7]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000};
        vecs[8]  = '{32'h00400000, 32'h3F800000, 32'h3F800000};
        vecs[9]  = '{32'h80000000, 32'h80000000, 32'h80000000};
        vecs[10] = '{32'h00000000, 32'h80000000, 32'h00000000};
        vecs[11] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000};
        vecs[12] = '{32'h3F800000, 32'h7F800000, 32'h7F800000};
        vecs[13] = '{32'hFF800000, 32'h40A00000, 32'hFF800000};
        vecs[14] = '{32'h3F800000, 32'hBF7FFFFF, 32'h33800000};
        vecs[15] = '{32'h3FFFFFFF, 32'h33800000, 32'h40000000};
        vecs[16] = '{32'h00800000, 32'h80800001, 32'h80000000};
        vecs[17] = '{32'hC0000000, 32'h3F800000, 32'hBF800000};

        reset = 1'b1; enable = 1'b0; add_start = 1'b0; add_a = '0; add_b = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'b0, add_ready}, 32'h0);
        check("reset_sum", add_sum, 32'h0);
        reset = 1'b0;
        enable = 1'b1;

        // Table-driven arithmetic vectors.
        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].a, vecs[i].b, sum, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd6);
            check($sformatf("vec%0d_sum", i), sum, vecs[i].exp);
            @(negedge clk);
            check($sformatf("vec%0d_pulse_width", i), {31'b0, add_ready}, 32'h0);
        end

        // Second start at T2 is ignored; sum stays stable afterwards.
        @(negedge clk);
        add_a = 32'h3F800000; add_b = 32'h40000000; add_start = 1'b1;
        @(negedge clk);
        add_start = 1'b0;
        @(negedge clk);
        add_a = 32'h40A00000; add_b = 32'hBFC00000; add_start = 1'b1;
        @(negedge clk);
        add_start = 1'b0;
        n = 2;
        while (n < 20 && !add_ready) begin
            @(negedge clk);
            n++;
        end
        check("t2_restart_latency", 32'(n), 32'd6);
        check("t2_restart_sum", add_sum, 32'h40400000);
        pulses = 0; unstable = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (add_ready) pulses++;
            if (add_sum !== 32'h40400000) unstable++;
        end
        check("t2_restart_extra_pulses", 32'(pulses), 32'd0);
        check("sum_hold_stable", 32'(unstable), 32'd0);

        // Start with enable low is ignored.
        enable = 1'b0;
        add_a = 32'h3F800000; add_b = 32'h3F800000; add_start = 1'b1;
        @(negedge clk);
        add_start = 1'b0;
        count_ready(12, pulses);
        check("disabled_pulses", 32'(pulses), 32'd0);
        check("disabled_sum_held", add_sum, 32'h40400000);
        enable = 1'b1;

        // Back-to-back: new start in the ready cycle.
        run_op(32'h40A00000, 32'hBFC00000, sum, lat);
        check("b2b_first_latency", 32'(lat), 32'd6);
        check("b2b_first_sum", sum, 32'h40600000);
        add_a = 32'h3F800000; add_b = 32'h40000000; add_start = 1'b1;
        @(negedge clk);
        add_start = 1'b0;
        check("b2b_gap_ready_low", {31'b0, add_ready}, 32'h0);
        n = 0;
        while (n < 20 && !add_ready) begin
            @(negedge clk);
            n++;
        end
        check("b2b_second_latency", 32'(n), 32'd6);
        check("b2b_second_sum", add_sum, 32'h40400000);

        // Reset at T3 aborts the operation.
        @(negedge clk);
        add_a = 32'h3F800000; add_b = 32'h3F800000; add_start = 1'b1;
        @(negedge clk);
        add_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_sum_cleared", add_sum, 32'h0);
        count_ready(10, pulses);
        check("abort_no_pulse", 32'(pulses), 32'd0);
        run_op(32'h3F800000, 32'h3F800000, sum, lat);
        check("after_abort_latency", 32'(lat), 32'd6);
        check("after_abort_sum", sum, 32'h40000000);
        @(negedge clk);

        // Reset and start in the same cycle: start is dropped.
        add_a = 32'h3F800000; add_b = 32'h40000000;
        reset = 1'b1; add_start = 1'b1;
        @(negedge clk);
        reset = 1'b0; add_start = 1'b0;
        count_ready(10, pulses);
        check("reset_start_dropped", 32'(pulses), 32'd0);
        check("reset_start_sum", add_sum, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
